nofx2_frame_packer: RTL and testbench



---
 rtl/nofx2_frame_packer_if.sv | 26 ++
 rtl/nofx2_frame_packer.sv | 185 ++++++++++++++++++
 tb/tb_nofx2_frame_packer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nofx2_frame_packer_if.sv
// Handshake bundle for nofx2_frame_packer.
// The narrow word stream comes in and the wide beat stream goes out.
// master: the packer itself (accepts words, drives beats).
// slave : the surrounding logic (feeds words, consumes beats).
interface nofx2_frame_packer_if #(
    parameter int WORD_W = 16,
    parameter int LANES  = 2
);
    logic [WORD_W-1:0]       in_dat_i;
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [WORD_W*LANES-1:0] out_dat_o;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic                    out_last_o;

    modport master (
        input  in_dat_i, in_valid_i, out_ready_i,
        output in_ready_o, out_dat_o, out_valid_o, out_last_o
    );

    modport slave (
        output in_dat_i, in_valid_i, out_ready_i,
        input  in_ready_o, out_dat_o, out_valid_o, out_last_o
    );
endinterface

// File: rtl/nofx2_frame_packer.sv
// nofx2_frame_packer: packs length-framed event words LANES at a time into
// wide beats for the event FIFO. Word 0 of a frame is the type, word 1 the
// total frame length in words. A frame tail is padded with PAD_WORD in the
// same cycle its last word is accepted.
// Optional feature macro: PACKER_STATS_EN adds frame_count_o / pad_count_o.
module nofx2_frame_packer #(
    parameter int                WORD_W    = 16,
    parameter int                LANES     = 2,
    parameter logic [WORD_W-1:0] PAD_WORD  = '0,
    parameter bit                BYTE_SWAP = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_i,
    nofx2_frame_packer_if.master bus,
    output logic                 busy_o,
    output logic                 len_err_o,
    output logic [21:0]          debug_o
`ifdef PACKER_STATS_EN
    ,
    output logic [31:0]          frame_count_o,
    output logic [15:0]          pad_count_o
`endif
);
    localparam int LW = $clog2(LANES);
    localparam int NB = WORD_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LENGTH = 2'd1,
        DATA   = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [LW-1:0]                 lane_q, lane_d;
    logic [15:0]                   rem_q, rem_d;
    logic [LANES-2:0][WORD_W-1:0]  accum_q;
    logic [LANES-1:0][WORD_W-1:0]  beat_d;
    logic [LANES-1:0][WORD_W-1:0]  out_dat_q;
    logic                          out_valid_q;
    logic                          out_last_q;
    logic                          len_err_q;
    logic                          accept;
    logic                          is_final;
    logic                          beat_done;
    logic                          short_len;
    logic [WORD_W-1:0]             word_sw;
    logic [15:0]                   len_word;

    // The input side only stalls when a finished beat cannot leave.
    assign bus.in_ready_o = !out_valid_q || bus.out_ready_i;
    assign accept         = bus.in_valid_i && bus.in_ready_o;

    // The length field is taken from the raw word, before any byte swap.
    assign len_word = 16'(bus.in_dat_i);

    generate
        if (BYTE_SWAP) begin : g_swap
            for (genvar b = 0; b < NB; b++) begin : g_byte
                assign word_sw[b*8 +: 8] = bus.in_dat_i[(NB-1-b)*8 +: 8];
            end
        end else begin : g_noswap
            assign word_sw = bus.in_dat_i;
        end
    endgenerate

    // Frame tracking: decide whether the accepted word closes its frame.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        is_final  = 1'b0;
        short_len = 1'b0;
        if (accept) begin
            case (state_q)
                IDLE: state_d = LENGTH;
                LENGTH: begin
                    short_len = (len_word < 16'd2);
                    // Lengths 0 and 1 are treated as 2: the frame ends here.
                    if (len_word <= 16'd2) begin
                        rem_d    = '0;
                        is_final = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        rem_d   = len_word - 16'd2;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        is_final = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Beat assembly: held lanes below, current word at lane, pad above.
    always_comb begin
        beat_done = accept && ((lane_q == LW'(LANES-1)) || is_final);
        lane_d    = lane_q;
        if (accept)
            lane_d = beat_done ? '0 : lane_q + LW'(1);
        for (int i = 0; i < LANES; i++)
            beat_d[i] = PAD_WORD;
        for (int i = 0; i < LANES-1; i++)
            if (i < int'(lane_q))
                beat_d[i] = accum_q[i];
        for (int i = 0; i < LANES; i++)
            if (i == int'(lane_q))
                beat_d[i] = word_sw;
    end

    // State, lane and remaining-count registers.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            lane_q    <= '0;
            rem_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            rem_q     <= rem_d;
            len_err_q <= short_len;
        end
    end

    // Park words that do not complete a beat; the top lane never needs it.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            accum_q <= '0;
        end else if (accept && !beat_done) begin
            for (int i = 0; i < LANES-1; i++)
                if (i == int'(lane_q))
                    accum_q[i] <= word_sw;
        end
    end

    // Output register: load wins over clear so load+consume keeps streaming.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            out_dat_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (beat_done) begin
            out_dat_q   <= beat_d;
            out_valid_q <= 1'b1;
            out_last_q  <= is_final;
        end else if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_dat_o   = out_dat_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_last_o  = out_last_q;
    assign busy_o          = (state_q != IDLE) || (lane_q != '0);
    assign len_err_o       = len_err_q;
    assign debug_o         = {state_q, 4'(lane_q), rem_q};

`ifdef PACKER_STATS_EN
    logic [31:0] frame_cnt_q;
    logic [15:0] pad_cnt_q;
    logic [16:0] pad_sum;

    // Pad lanes in the closing beat are the lanes above the final word.
    assign pad_sum = {1'b0, pad_cnt_q} + 17'(LANES-1) - 17'(lane_q);

    // Frame counter wraps; pad counter saturates.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            frame_cnt_q <= '0;
            pad_cnt_q   <= '0;
        end else if (accept && is_final) begin
            frame_cnt_q <= frame_cnt_q + 32'd1;
            pad_cnt_q   <= pad_sum[16] ? 16'hFFFF : pad_sum[15:0];
        end
    end

    assign frame_count_o = frame_cnt_q;
    assign pad_count_o   = pad_cnt_q;
`endif
endmodule

// File: tb/tb_nofx2_frame_packer.sv
// Bench for nofx2_frame_packer: two instances (2 lanes with byte swap,
// 4 lanes without) fed the same frame list, each with its own random
// output backpressure. Expected beats come from a frame-list model.
`timescale 1ns/1ps
module tb_nofx2_frame_packer;
    logic clk = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;

    nofx2_frame_packer_if #(.WORD_W(16), .LANES(2)) if0 ();
    nofx2_frame_packer_if #(.WORD_W(16), .LANES(4)) if1 ();

    logic        busy0, busy1, lerr0, lerr1;
    logic [21:0] dbg0, dbg1;
`ifdef PACKER_STATS_EN
    logic [31:0] fc0, fc1;
    logic [15:0] pc0, pc1;
`endif

    nofx2_frame_packer #(.WORD_W(16), .LANES(2), .PAD_WORD(16'h0000), .BYTE_SWAP(1'b1)) u0 (
        .clk(clk), .rst_i(rst_i), .bus(if0), .busy_o(busy0), .len_err_o(lerr0), .debug_o(dbg0)
`ifdef PACKER_STATS_EN
        , .frame_count_o(fc0), .pad_count_o(pc0)
`endif
    );

    nofx2_frame_packer #(.WORD_W(16), .LANES(4), .PAD_WORD(16'h0000), .BYTE_SWAP(1'b0)) u1 (
        .clk(clk), .rst_i(rst_i), .bus(if1), .busy_o(busy1), .len_err_o(lerr1), .debug_o(dbg1)
`ifdef PACKER_STATS_EN
        , .frame_count_o(fc1), .pad_count_o(pc1)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [15:0] words[$];
    bit          fin[$];
    int          ndir = 0;
    int          nfr = 0;
    int          nlerr = 0;

    logic [64:0] exp_beats [0:1][0:4095];
    int          exp_n [0:1] = '{0, 0};
    int          exp_h [0:1] = '{0, 0};
    int          pad_exp [0:1] = '{0, 0};
    bit          chk_en = 1'b0;
    bit          prev_stall [0:1] = '{1'b0, 1'b0};
    logic [64:0] prev_out [0:1];
    bit          prev_lerr [0:1] = '{1'b0, 1'b0};
    int          lerr_seen [0:1] = '{0, 0};

    task automatic check(input string nm, input logic [64:0] act, input logic [64:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] w, input bit f);
        words.push_back(w);
        fin.push_back(f);
    endtask

    // Random frame: type, length 0..12, then max(L,2)-2 payload words.
    task automatic add_rand_frame();
        logic [15:0] ty;
        int          len, nd;
        ty  = 16'($urandom);
        len = $urandom_range(0, 12);
        nd  = (len < 2) ? 0 : len - 2;
        push(ty, 1'b0);
        push(16'(len), nd == 0);
        for (int j = 0; j < nd; j++)
            push(16'($urandom), j == nd - 1);
        nfr++;
        if (len < 2) nlerr++;
    endtask

    // Model: chop the word list into groups of `lanes`, cutting early at each
    // frame end; unused lanes hold the pad value 0.
    task automatic build(input int k, input int lanes, input bit swap);
        logic [15:0] grp [0:7];
        logic [64:0] beat;
        int          fill;
        fill = 0;
        for (int i = 0; i < words.size(); i++) begin
            grp[fill] = swap ? {words[i][7:0], words[i][15:8]} : words[i];
            fill++;
            if (fill == lanes || fin[i]) begin
                beat = '0;
                for (int j = 0; j < lanes; j++)
                    beat[j*16 +: 16] = (j < fill) ? grp[j] : 16'h0000;
                beat[64] = fin[i];
                exp_beats[k][exp_n[k]] = beat;
                exp_n[k]++;
                if (fin[i]) pad_exp[k] += lanes - fill;
                fill = 0;
            end
        end
    endtask

    task automatic cmp(input int k, input logic v, input logic r, input logic ir,
                       input logic last, input logic [63:0] dat, input logic le);
        check($sformatf("in_ready%0d", k), 65'(ir), 65'(!v || r));
        if (prev_stall[k]) begin
            check($sformatf("stall_valid%0d", k), 65'(v), 65'd1);
            check($sformatf("stall_hold%0d", k), {last, dat}, prev_out[k]);
        end
        if (v && r) begin
            if (exp_h[k] >= exp_n[k]) begin
                n_chk++;
                n_fail++;
                $display("FAIL extra_beat%0d: got %h expected no beat", k, {last, dat});
            end else begin
                check($sformatf("beat%0d_%0d", k, exp_h[k]), {last, dat}, exp_beats[k][exp_h[k]]);
                exp_h[k]++;
            end
        end
        if (le) begin
            lerr_seen[k]++;
            check($sformatf("len_err_width%0d", k), 65'(prev_lerr[k]), 65'd0);
        end
        prev_lerr[k]  = le;
        prev_stall[k] = v && !r;
        prev_out[k]   = {last, dat};
    endtask

    // Single compare process, sampling away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, if0.out_valid_o, if0.out_ready_i, if0.in_ready_o, if0.out_last_o,
                {32'h0, if0.out_dat_o}, lerr0);
            cmp(1, if1.out_valid_o, if1.out_ready_i, if1.in_ready_o, if1.out_last_o,
                if1.out_dat_o, lerr1);
        end
    end

    function automatic logic pick_ready(input int idx, inout int hold);
        if (idx < ndir) return 1'b1;
        if (hold < 5) begin
            hold++;
            return 1'b0;
        end
        return ($urandom_range(0, 9) < 7);
    endfunction

    initial begin
        int  idx [0:1];
        int  hold [0:1];
        int  cyc;
        int  nw;
        bit  a0, a1;
        logic [15:0] rw [0:2];

        if0.in_valid_i = 1'b0; if0.in_dat_i = '0; if0.out_ready_i = 1'b1;
        if1.in_valid_i = 1'b0; if1.in_dat_i = '0; if1.out_ready_i = 1'b1;

        // Directed frames first, then random ones.
        push(16'h4500, 0); push(16'h0003, 0); push(16'h1234, 1);
        push(16'h4500, 0); push(16'h0004, 0); push(16'hAAAA, 0); push(16'hBBBB, 1);
        push(16'h4600, 0); push(16'h0002, 1);
        push(16'h0001, 0); push(16'h0005, 0); push(16'h0A0A, 0); push(16'h0B0B, 0); push(16'h0C0C, 1);
        push(16'h1111, 0); push(16'h0000, 1);
        nfr = 5; nlerr = 1;
        ndir = words.size();
        for (int f = 0; f < 60; f++) add_rand_frame();
        nw = words.size();
        build(0, 2, 1'b1);
        build(1, 4, 1'b0);

        // Hand-computed values pinning the model.
        check("model_t1_beat1", exp_beats[0][0], {1'b0, 32'h0, 32'h03000045});
        check("model_t1_beat2", exp_beats[0][1], {1'b1, 32'h0, 32'h00003412});
        check("model_t2_beat1", exp_beats[0][2], {1'b0, 32'h0, 32'h04000045});
        check("model_t2_beat2", exp_beats[0][3], {1'b1, 32'h0, 32'hBBBBAAAA});
        check("model_t2_beat3", exp_beats[0][4], {1'b1, 32'h0, 32'h02000046});
        check("model_t3_beat1", exp_beats[1][3], {1'b0, 64'h0B0B0A0A00050001});
        check("model_t3_beat2", exp_beats[1][4], {1'b1, 64'h0000000000000C0C});
        check("model_t5_beat0", exp_beats[0][8], {1'b1, 32'h0, 32'h00001111});
        check("model_t5_beat1", exp_beats[1][5], {1'b1, 64'h0000000000001111});

        // Reset state.
        #3;
        check("rst_valid0", 65'(if0.out_valid_o), 65'd0);
        check("rst_dat0", 65'(if0.out_dat_o), 65'd0);
        check("rst_last0", 65'(if0.out_last_o), 65'd0);
        check("rst_busy0", 65'(busy0), 65'd0);
        check("rst_lerr0", 65'(lerr0), 65'd0);
        check("rst_dbg0", 65'(dbg0[19:0]), 65'd0);
        check("rst_inready0", 65'(if0.in_ready_o), 65'd1);
        check("rst_valid1", 65'(if1.out_valid_o), 65'd0);
        @(negedge clk);
        rst_i = 1'b0;

        // Partial frame, then asynchronous reset mid-DATA with lane 1.
        rw[0] = 16'h4500; rw[1] = 16'h0005; rw[2] = 16'hAAAA;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            if0.in_valid_i = 1'b1; if0.in_dat_i = rw[i];
            if1.in_valid_i = 1'b1; if1.in_dat_i = rw[i];
            @(posedge clk); #1;
        end
        if0.in_valid_i = 1'b0; if1.in_valid_i = 1'b0;
        check("pre_rst_lane0", 65'(dbg0[19:16]), 65'd1);
        check("pre_rst_busy0", 65'(busy0), 65'd1);
        #2 rst_i = 1'b1;
        #1;
        check("async_rst_valid0", 65'(if0.out_valid_o), 65'd0);
        check("async_rst_dat0", 65'(if0.out_dat_o), 65'd0);
        check("async_rst_busy0", 65'(busy0), 65'd0);
        check("async_rst_dbg0", 65'(dbg0[19:0]), 65'd0);
        check("async_rst_dat1", 65'(if1.out_dat_o), 65'd0);
        check("async_rst_busy1", 65'(busy1), 65'd0);
        @(negedge clk);
        rst_i  = 1'b0;
        chk_en = 1'b1;

        // Stream all words; each instance advances on its own acceptances.
        idx[0] = 0; idx[1] = 0; hold[0] = 0; hold[1] = 0; cyc = 0;
        @(posedge clk); #1;
        if0.in_valid_i = 1'b1; if0.in_dat_i = words[0];
        if1.in_valid_i = 1'b1; if1.in_dat_i = words[0];
        while ((idx[0] < nw || idx[1] < nw) && cyc < 30000) begin
            @(negedge clk);
            a0 = if0.in_valid_i && if0.in_ready_o;
            a1 = if1.in_valid_i && if1.in_ready_o;
            @(posedge clk); #1;
            cyc++;
            if (a0) idx[0]++;
            if (a1) idx[1]++;
            if (!(if0.in_valid_i && !a0)) begin
                if (idx[0] < nw && (idx[0] < ndir || $urandom_range(0, 3) != 0)) begin
                    if0.in_valid_i = 1'b1; if0.in_dat_i = words[idx[0]];
                end else if0.in_valid_i = 1'b0;
            end
            if (!(if1.in_valid_i && !a1)) begin
                if (idx[1] < nw && (idx[1] < ndir || $urandom_range(0, 3) != 0)) begin
                    if1.in_valid_i = 1'b1; if1.in_dat_i = words[idx[1]];
                end else if1.in_valid_i = 1'b0;
            end
            if0.out_ready_i = pick_ready(idx[0], hold[0]);
            if1.out_ready_i = pick_ready(idx[1], hold[1]);
        end
        if (cyc >= 30000) begin
            n_chk++; n_fail++;
            $display("FAIL stim_timeout: got %0d/%0d and %0d/%0d words required all", idx[0], nw, idx[1], nw);
        end
        if0.in_valid_i = 1'b0; if1.in_valid_i = 1'b0;
        if0.out_ready_i = 1'b1; if1.out_ready_i = 1'b1;

        cyc = 0;
        while ((exp_h[0] < exp_n[0] || exp_h[1] < exp_n[1]) && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;

        check("beats_delivered0", 65'(exp_h[0]), 65'(exp_n[0]));
        check("beats_delivered1", 65'(exp_h[1]), 65'(exp_n[1]));
        check("len_err_count0", 65'(lerr_seen[0]), 65'(nlerr));
        check("len_err_count1", 65'(lerr_seen[1]), 65'(nlerr));
        check("end_busy0", 65'(busy0), 65'd0);
        check("end_busy1", 65'(busy1), 65'd0);
        check("end_valid0", 65'(if0.out_valid_o), 65'd0);
`ifdef PACKER_STATS_EN
        check("frame_count0", 65'(fc0), 65'(nfr));
        check("frame_count1", 65'(fc1), 65'(nfr));
        check("pad_count0", 65'(pc0), 65'(pad_exp[0]));
        check("pad_count1", 65'(pc1), 65'(pad_exp[1]));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
